// File: rtl/bp_fe_queue_rollback_fifo.sv
// FE->BE queue with speculative read, commit and rollback pointers.
// Define BP_FE_QUEUE_BYPASS_EN for same-cycle enqueue-to-output bypass.
module bp_fe_queue_rollback_fifo #(
  parameter int els_p   = 8,
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] fe_queue_i,
  input  logic               fe_queue_v_i,
  output logic               fe_queue_ready_o,
  output logic [width_p-1:0] fe_queue_o,
  output logic               fe_queue_v_o,
  input  logic               fe_queue_yumi_i,
  input  logic               fe_queue_deq_i,
  input  logic               fe_queue_roll_i,
  input  logic               fe_queue_clr_i,
  output logic               empty_o
);

  localparam int IW = $clog2(els_p);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] ELS = PW'(els_p);
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] NIL = '0;

  logic [width_p-1:0] mem_q [els_p];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] cptr_q, cptr_d;
  logic          rdy_q;
  logic          full;
  logic          unread;
  logic          enq;

  assign full   = (wptr_q - cptr_q) == ELS;
  assign unread = rptr_q != wptr_q;

  // rdy_q holds ready low until the first edge after reset release
  assign fe_queue_ready_o = rdy_q & ~full;
  assign enq              = fe_queue_v_i & fe_queue_ready_o;
  assign empty_o          = wptr_q == cptr_q;

`ifdef BP_FE_QUEUE_BYPASS_EN
  logic byp;
  assign byp          = ~unread & enq;
  assign fe_queue_v_o = unread | byp;
  assign fe_queue_o   = byp ? fe_queue_i
                            : mem_q[rptr_q[IW-1:0]];
`else
  assign fe_queue_v_o = unread;
  assign fe_queue_o   = mem_q[rptr_q[IW-1:0]];
`endif

  always_comb begin
    wptr_d = wptr_q + (enq ? ONE : NIL);
    cptr_d = cptr_q + (fe_queue_deq_i ? ONE : NIL);
    rptr_d = rptr_q + (fe_queue_yumi_i ? ONE : NIL);
    if (fe_queue_clr_i) begin
      cptr_d = wptr_d;
      rptr_d = wptr_d;
    end else if (fe_queue_roll_i) begin
      rptr_d = cptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
      rdy_q  <= 1'b1;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q[IW-1:0]] <= fe_queue_i;
  end

`ifndef SYNTHESIS
  a_yumi_v: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    fe_queue_yumi_i |-> fe_queue_v_o);

  a_deq_ok: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    (fe_queue_deq_i & ~fe_queue_clr_i) |-> (cptr_q != rptr_q));

  a_data_x: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    fe_queue_v_i |-> !$isunknown(fe_queue_i));
`endif

endmodule

// File: tb/tb_bp_fe_queue_rollback_fifo.sv
// Directed bench for bp_fe_queue_rollback_fifo at els_p=4.
// Expected values are hand-computed per vector.
module tb_bp_fe_queue_rollback_fifo;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] d_i;
  logic [W-1:0] q_o;
  logic         v_i, rdy, v_o;
  logic         yumi, deq, roll, clr;
  logic         empty;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bp_fe_queue_rollback_fifo #(
    .els_p  (N),
    .width_p(W)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .fe_queue_i      (d_i),
    .fe_queue_v_i    (v_i),
    .fe_queue_ready_o(rdy),
    .fe_queue_o      (q_o),
    .fe_queue_v_o    (v_o),
    .fe_queue_yumi_i (yumi),
    .fe_queue_deq_i  (deq),
    .fe_queue_roll_i (roll),
    .fe_queue_clr_i  (clr),
    .empty_o         (empty)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [W-1:0] d,
                     input logic y, input logic dq,
                     input logic rl, input logic cl);
    v_i  = v;
    d_i  = d;
    yumi = y;
    deq  = dq;
    roll = rl;
    clr  = cl;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    chk("rst_v", v_o, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_empty", empty, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_pre_edge", rdy, 0);
    tick();
    chk("rdy_post_edge", rdy, 1);

    // basic in-order flow
    drv(1, 16'h00A1, 0, 0, 0, 0);
`ifdef BP_FE_QUEUE_BYPASS_EN
    chk("byp_v_same", v_o, 1);
    chk("byp_q_same", q_o, 16'h00A1);
`else
    chk("lat_v_same", v_o, 0);
`endif
    tick();
    drv(1, 16'h00B2, 1, 0, 0, 0);
    chk("t1_vA", v_o, 1);
    chk("t1_qA", q_o, 16'h00A1);
    tick();
    drv(1, 16'h00C3, 1, 0, 0, 0);
    chk("t1_qB", q_o, 16'h00B2);
    tick();
    drv(0, '0, 1, 0, 0, 0);
    chk("t1_qC", q_o, 16'h00C3);
    chk("t1_empty0", empty, 0);
    tick();
    drv(0, '0, 0, 1, 0, 0);
    chk("t1_v_drained", v_o, 0);
    chk("t1_empty1", empty, 0);
    tick();
    drv(0, '0, 0, 1, 0, 0);
    chk("t1_empty2", empty, 0);
    tick();
    drv(0, '0, 0, 1, 0, 0);
    chk("t1_empty3", empty, 0);
    tick();
    idle();
    chk("t1_empty_end", empty, 1);

    // full / backpressure
    for (int i = 0; i < 4; i++) begin
      drv(1, 16'h0100 + 16'(i), 0, 0, 0, 0);
      chk($sformatf("t2_rdy%0d", i), rdy, 1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drv(1, 16'h0104, 0, 0, 0, 0);
      chk($sformatf("t2_full%0d", i), rdy, 0);
      tick();
    end
    drv(1, 16'h0104, 1, 0, 0, 0);
    chk("t2_q0", q_o, 16'h0100);
    chk("t2_rdy_yumi", rdy, 0);
    tick();
    drv(1, 16'h0104, 0, 1, 0, 0);
    chk("t2_rdy_deq", rdy, 0);
    tick();
    drv(1, 16'h0104, 0, 0, 0, 0);
    chk("t2_rdy_freed", rdy, 1);
    tick();
    for (int i = 1; i < 5; i++) begin
      drv(0, '0, 1, 0, 0, 0);
      chk($sformatf("t2_q%0d", i), q_o, 16'h0100 + 16'(i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drv(0, '0, 0, 1, 0, 0);
      tick();
    end
    idle();
    chk("t2_empty", empty, 1);
    chk("t2_v", v_o, 0);

    // roll after partial commit
    for (int i = 0; i < 3; i++) begin
      drv(1, 16'h0200 + 16'(i), 0, 0, 0, 0);
      tick();
    end
    drv(0, '0, 1, 0, 0, 0);
    chk("t3_qA", q_o, 16'h0200);
    tick();
    drv(0, '0, 1, 0, 0, 0);
    chk("t3_qB", q_o, 16'h0201);
    tick();
    drv(0, '0, 0, 1, 0, 0);
    tick();
    drv(0, '0, 0, 0, 1, 0);
    chk("t3_qC_pre", q_o, 16'h0202);
    tick();
    drv(0, '0, 1, 0, 0, 0);
    chk("t3_roll_v", v_o, 1);
    chk("t3_roll_qB", q_o, 16'h0201);
    tick();
    drv(0, '0, 1, 0, 0, 0);
    chk("t3_roll_qC", q_o, 16'h0202);
    tick();
    drv(0, '0, 0, 1, 0, 0);
    tick();
    drv(0, '0, 0, 1, 0, 0);
    tick();
    idle();
    chk("t3_empty", empty, 1);

    // roll + deq + yumi together
    for (int i = 0; i < 3; i++) begin
      drv(1, 16'h0300 + 16'(i), 0, 0, 0, 0);
      tick();
    end
    drv(0, '0, 1, 0, 0, 0);
    tick();
    drv(0, '0, 1, 0, 0, 0);
    tick();
    drv(0, '0, 1, 1, 1, 0);
    chk("t4_qC_pre", q_o, 16'h0302);
    tick();
    drv(0, '0, 1, 0, 0, 0);
    chk("t4_qB", q_o, 16'h0301);
    tick();
    drv(0, '0, 1, 0, 0, 0);
    chk("t4_qC", q_o, 16'h0302);
    tick();
    drv(0, '0, 0, 1, 0, 0);
    tick();
    drv(0, '0, 0, 1, 0, 0);
    tick();
    idle();
    chk("t4_empty", empty, 1);

    // clr while enqueuing
    for (int i = 0; i < 3; i++) begin
      drv(1, 16'h0400 + 16'(i), 0, 0, 0, 0);
      tick();
    end
    drv(1, 16'h0DDD, 1, 0, 0, 1);
    chk("t5_rdy", rdy, 1);
    tick();
    idle();
    chk("t5_empty", empty, 1);
    chk("t5_v", v_o, 0);
    tick();
    chk("t5_v2", v_o, 0);
    drv(1, 16'h0F0F, 0, 0, 0, 0);
    tick();
    drv(0, '0, 1, 0, 0, 0);
    chk("t5_qF", q_o, 16'h0F0F);
    tick();
    drv(0, '0, 0, 1, 0, 0);
    tick();
    idle();
    chk("t5_empty2", empty, 1);

    // wrap passes with roll
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) begin
        drv(1, 16'h0600 + 16'(p * 16 + i), 0, 0, 0, 0);
        tick();
      end
      drv(0, '0, 1, 0, 0, 0);
      tick();
      drv(0, '0, 1, 0, 0, 0);
      tick();
      drv(0, '0, 0, 0, 1, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
        drv(0, '0, 1, 0, 0, 0);
        chk($sformatf("t6_p%0d_q%0d", p, i), q_o,
            16'h0600 + 16'(p * 16 + i));
        tick();
      end
      for (int i = 0; i < 4; i++) begin
        drv(0, '0, 0, 1, 0, 0);
        tick();
      end
      idle();
      chk($sformatf("t6_p%0d_empty", p), empty, 1);
    end

    // asynchronous reset mid-stream
    drv(1, 16'h0700, 0, 0, 0, 0);
    tick();
    drv(1, 16'h0701, 1, 0, 0, 0);
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_v", v_o, 0);
    chk("t7_rdy", rdy, 0);
    chk("t7_empty", empty, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t7_rdy_back", rdy, 1);
    chk("t7_v_back", v_o, 0);

`ifdef BP_FE_QUEUE_BYPASS_EN
    drv(1, 16'h0800, 1, 0, 0, 0);
    chk("t8_v", v_o, 1);
    chk("t8_q", q_o, 16'h0800);
    tick();
    drv(0, '0, 0, 0, 1, 0);
    chk("t8_v_after", v_o, 0);
    tick();
    drv(0, '0, 1, 0, 0, 0);
    chk("t8_replay_v", v_o, 1);
    chk("t8_replay_q", q_o, 16'h0800);
    tick();
    drv(0, '0, 0, 1, 0, 0);
    tick();
    idle();
    chk("t8_empty", empty, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
